// File: rtl/reg_pkg.sv
// Shared widths and types for the architectural register file.
// Imported by the register file and its hazard scoreboard.
package reg_pkg;

  localparam int D_SIZE     = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [D_SIZE-1:0]     reg_data_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write tracker for the register file.
// Flags read-after-write hazards for decode.
module reg_scoreboard
  import reg_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      wb_we_i,
  input  reg_addr_t wb_addr_i,
  input  logic      iss_en_i,
  input  reg_addr_t iss_addr_i,
  input  logic      rd_en_i,
  input  reg_addr_t rs1_addr_i,
  input  reg_addr_t rs2_addr_i,
  output logic      hazard_o
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;
  logic                haz1;
  logic                haz2;

  // Set after clear: a newly issued producer outranks the retiring one.
  always_comb begin
    pend_d = pend_q;
    if (wb_we_i)
      pend_d[wb_addr_i] = 1'b0;
    if (iss_en_i && (iss_addr_i != '0))
      pend_d[iss_addr_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      pend_q <= '0;
    else
      pend_q <= pend_d;
  end

  assign haz1 = (rs1_addr_i != '0)
             && pend_q[rs1_addr_i]
             && !(wb_we_i && (wb_addr_i == rs1_addr_i));
  assign haz2 = (rs2_addr_i != '0)
             && pend_q[rs2_addr_i]
             && !(wb_we_i && (wb_addr_i == rs2_addr_i));

  assign hazard_o = rd_en_i && (haz1 || haz2);

endmodule

// File: rtl/reg_file.sv
// Architectural register file: one write-back port, two
// registered read ports with same-cycle bypass.
module reg_file
  import reg_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      wb_we,
  input  reg_addr_t wb_addr,
  input  reg_data_t wb_data,
  input  logic      rd_en,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  output reg_data_t rs1_data,
  output reg_data_t rs2_data,
  output logic      rd_valid,
  input  logic      iss_en,
  input  reg_addr_t iss_addr,
  output logic      hazard
);

  reg_data_t regs_q [NUM_REGS];
  reg_data_t rs1_q;
  reg_data_t rs1_d;
  reg_data_t rs2_q;
  reg_data_t rs2_d;
  logic      rd_valid_q;

  always_comb begin
    rs1_d = regs_q[rs1_addr];
    if (wb_we && (wb_addr == rs1_addr))
      rs1_d = wb_data;
    if (rs1_addr == '0)
      rs1_d = '0;
  end

  always_comb begin
    rs2_d = regs_q[rs2_addr];
    if (wb_we && (wb_addr == rs2_addr))
      rs2_d = wb_data;
    if (rs2_addr == '0)
      rs2_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wb_we && (wb_addr != '0))
        regs_q[wb_addr] <= wb_data;
      if (rd_en) begin
        rs1_q      <= rs1_d;
        rs2_q      <= rs2_d;
        rd_valid_q <= 1'b1;
      end else begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  assign rs1_data = rs1_q;
  assign rs2_data = rs2_q;
  assign rd_valid = rd_valid_q;

  reg_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_we_i    (wb_we),
    .wb_addr_i  (wb_addr),
    .iss_en_i   (iss_en),
    .iss_addr_i (iss_addr),
    .rd_en_i    (rd_en),
    .rs1_addr_i (rs1_addr),
    .rs2_addr_i (rs2_addr),
    .hazard_o   (hazard)
  );

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file for the five-stage pipeline: the receiving end of the write-back path. It accepts one register write per cycle from the write-back stage and serves two synchronous read ports to decode. Same-cycle write-to-read bypass is built in. A pending-write scoreboard flags read-after-write hazards so decode can stall until the producing instruction reaches write-back.

## Interface
Parameters:
- D_SIZE, 32, data width of each register
- NUM_REGS, 32, number of architectural registers; x0 hardwired to zero
- REG_ADDR_W, 5, register index width, equal to log2(NUM_REGS)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- wb_we  in  1  write enable (regWrite) from write-back
- wb_addr  in  REG_ADDR_W  destination register from write-back
- wb_data  in  D_SIZE  write data from write-back
- rd_en  in  1  decode read request
- rs1_addr, rs2_addr  in  REG_ADDR_W  source register indices
- rs1_data, rs2_data  out  D_SIZE  registered read data
- rd_valid  out  1  read data valid; registered
- iss_en  in  1  instruction with register destination issued past decode
- iss_addr  in  REG_ADDR_W  destination of issued instruction
- hazard  out  1  combinational; a source of the current read is pending

## Operation
- Writes:
  - on an edge with wb_we=1 and wb_addr!=0: regs[wb_addr] <= wb_data.
  - writes to x0 are dropped.
- Reads:
  - on an edge with rd_en=1: rsN_data <= value(rsN_addr); rd_valid <= 1.
  - rd_en=0: rd_valid <= 0 and rsN_data hold their previous value.
- value(a):
  - 0 when a==0;
  - otherwise wb_data when wb_we=1 and wb_addr==a (bypass);
  - otherwise regs[a].
- Scoreboard: one pending bit per register; bit 0 is never set.
  - clear: wb_we=1 clears pending[wb_addr].
  - set: iss_en=1 with iss_addr!=0 sets pending[iss_addr].
  - set and clear of the same index in the same cycle: set wins, because a new producer is in flight.
- hazard = rd_en and any N in {1,2} with rsN_addr!=0 and pending[rsN_addr], and not (wb_we and wb_addr==rsN_addr).
  - A register that is being written back this cycle is covered by the bypass, so it raises no hazard.
- The block does not consume the hazard. Decode holds rd_en, the addresses and iss_en stable while hazard=1; the registered outputs of a hazarded read are don't-care.

## Timing
- Reset: when rst_n=0 at an edge:
  - all regs, rs1_data, rs2_data and all pending bits become 0;
  - rd_valid becomes 0.
- Reset asserted mid-operation discards in-flight writes and issues from that edge. The first edge with rst_n=1 behaves as normal.
- Read latency: 1 cycle from rd_en to rd_valid and data.
- Write-to-read latency: 0 cycles via the bypass.
- hazard has zero latency and depends on current inputs plus the pending state.
- A pending bit set at edge t is visible to hazard in cycle t+1.

## Structure
- Shared package reg_pkg holds:
  - D_SIZE, NUM_REGS, REG_ADDR_W;
  - typedef reg_addr_t (logic [REG_ADDR_W-1:0]);
  - typedef reg_data_t (logic [D_SIZE-1:0]).
- Sub-module reg_scoreboard holds:
  - the pending vector, with its set/clear priority;
  - the hazard compare.
- The storage array, bypass muxes and output registers stay in reg_file.

## Test plan
- Reset, then read x1/x2 with rd_en=1:
  - 0 and 0 next cycle, rd_valid=1;
  - rd_valid=0 the cycle after rst_n was released with rd_en=0.
- Write x5=0xDEADBEEF at cycle t, read rs1=5 at t+1 -> rs1_data=0xDEADBEEF.
- Same-cycle bypass: write x7=0x1234 while reading rs2=7 -> rs2_data=0x1234 next cycle.
- Write x0=0xFFFFFFFF, then read rs1=0 -> 0. iss_en with iss_addr=0 -> hazard stays 0.
- Scoreboard:
  - iss_en x9; next cycle read rs1=9 -> hazard=1.
  - wb_we x9=0x55 with rs1=9 -> hazard=0 and data 0x55.
  - iss x9 and wb x9 in the same cycle -> pending[9] stays 1.
- Reset mid-op: set pending x3 and write x3=0xA, assert rst_n=0 for one edge -> read x3 returns 0 and hazard=0.
